uart_tx: RTL and testbench
==========================

Name: uart_tx

Overview:
Synthesizable UART transmitter: serializes bytes from a parallel producer onto a single TX line. Frame format is 8N1, LSB first, idle high. Includes a small byte FIFO so a producer (e.g. a message/ASCII formatter) can burst bytes without waiting a full frame each. Sits between on-chip logic and the board's USB-UART bridge pin.

Parameters:
CLK_FREQ, 100000000, system clock frequency in Hz.
BAUD, 115200, line rate in bit/s.
DIVISOR, CLK_FREQ/BAUD (868), clocks per bit; integer truncation; must be >= 2.
FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW = 16 bytes.

Ports:
clk  input  1  system clock, all logic on rising edge.
rst  input  1  asynchronous, active-high reset.
tx_data  input  8  byte to send.
tx_valid  input  1  producer offers tx_data this cycle.
tx_ready  output  1  FIFO can accept; byte is taken on an edge where tx_valid && tx_ready.
tx  output  1  serial line, registered, idle 1.
busy  output  1  frame in progress or FIFO non-empty.
fifo_count  output  FIFO_AW+1  bytes currently queued, excluding the byte being shifted.

Behaviour:
- Reset (async, immediate): tx=1, busy=0, tx_ready=1, fifo_count=0, FSM=IDLE, FIFO pointers=0, baud counter=0, bit index=0. Reset mid-frame truncates the frame; tx goes high without waiting for a clock.
- tx_ready = (fifo_count != 2**FIFO_AW). Combinational from registered count.
- FIFO write only on tx_valid && tx_ready. Write while full is ignored; no overwrite.
- Push and pop on the same edge leave count unchanged.
- FSM states:
  - IDLE: tx=1. If FIFO is non-empty, pop the head into the shift register, set tx=0, clear the baud counter, go to START.
  - START: hold tx=0 for DIVISOR cycles, then go to DATA with bit index 0 and tx=shift[0].
  - DATA: hold each bit for DIVISOR cycles, LSB first. After bit 7 completes, go to STOP with tx=1.
  - STOP: hold tx=1 for DIVISOR cycles. If the FIFO is non-empty at the end, pop and go straight to START with tx=0 (back-to-back, no idle gap). Otherwise go to IDLE.
- Latency: byte accepted at edge N into an empty FIFO with FSM in IDLE -> tx falls at edge N+1. Frame is exactly 10*DIVISOR cycles.
- Baud counter counts 0..DIVISOR-1, width $clog2(DIVISOR). Bit transitions occur when the counter equals DIVISOR-1. No fractional-rate correction.
- tx_data is sampled only at the accept edge; later changes do not affect a queued byte.
- busy = (FSM != IDLE) || (fifo_count != 0).
- Pointers wrap modulo depth. Full/empty are derived from the FAW+1-bit count.

Optional Feature:
UART_TX_PARITY_EN.
- Defined: state PARITY is inserted between DATA and STOP. It drives the even-parity bit (XOR of the 8 data bits) for DIVISOR cycles. Frame becomes 11*DIVISOR cycles.
- Undefined: no PARITY state and no parity logic; 8N1 framing, 10 bits per frame.

Decomposition:
- Package uart_pkg holds:
  - FSM state encoding: IDLE=0, START=1, DATA=2, PARITY=3, STOP=4; 3-bit.
  - Constants: UART_DATA_BITS=8, UART_IDLE_LVL=1'b1.
  - A function computing the divisor from CLK_FREQ/BAUD.
- One sub-module: uart_tx_fifo, a synchronous FIFO parameterized by width and FIFO_AW. It provides push/pop/count/full/empty with single-cycle read of the head. The FSM and baud counter stay in uart_tx.

Test Plan:
- Use CLK_FREQ=1152000, BAUD=115200 (DIVISOR=10).
- Single byte: push 0xA5 while idle -> tx falls 1 cycle after accept. Line reads 0,1,0,1,0,0,1,0,1,1, each bit 10 cycles. Mid-bit sampling decodes 0xA5. busy drops at cycle 101.
- Back-to-back: push "H","i","\r" consecutively -> three contiguous 100-cycle frames with no idle cycles between stop and next start. Decoder yields 0x48, 0x69, 0x0D.
- Full FIFO: hold tx_valid=1 every cycle from idle -> exactly 17 bytes accepted (1 popped immediately plus 16 queued). tx_ready goes low, fifo_count=16. tx_ready rises one cycle after the next pop. No byte is lost or duplicated over 40 bytes.
- Reset mid-frame: assert rst during bit 3 of 0x3C with 5 bytes queued -> tx=1 immediately, fifo_count=0, tx_ready=1. A subsequent push of 0x55 produces a clean frame.
- Data stability: change tx_data on the cycle after accept (0x0F then 0xF0 held) -> transmitted byte is 0x0F.
- With UART_TX_PARITY_EN: push 0x07 -> parity bit=1, frame 110 cycles. Push 0x03 -> parity bit=0.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmitter: FSM encoding, framing constants
// and the clocks-per-bit helper.
package uart_pkg;

   typedef enum logic [2:0] {
      ST_IDLE   = 3'd0,
      ST_START  = 3'd1,
      ST_DATA   = 3'd2,
      ST_PARITY = 3'd3,
      ST_STOP   = 3'd4
   } uart_state_t;

   localparam int   UART_DATA_BITS = 8;
   localparam logic UART_IDLE_LVL  = 1'b1;

   // Truncating division; no fractional baud correction is attempted.
   function automatic int uart_divisor(input int clk_freq, input int baud);
      return clk_freq / baud;
   endfunction

endpackage

// File: rtl/uart_tx_fifo.sv
// Synchronous byte FIFO with a combinational head read; full/empty come from
// an AW+1 bit occupancy count so pointers can simply wrap.
module uart_tx_fifo #(
   parameter int WIDTH = 8,
   parameter int AW    = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic [WIDTH-1:0] push_data,
   input  logic             pop,
   output logic [WIDTH-1:0] head,
   output logic [AW:0]      count,
   output logic             full,
   output logic             empty
);
   localparam int DEPTH = 2 ** AW;

   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0]    wr_ptr;
   logic [AW-1:0]    rd_ptr;
   logic             do_push;
   logic             do_pop;

   assign full    = (count == (AW+1)'(DEPTH));
   assign empty   = (count == '0);
   assign do_push = push && !full;
   assign do_pop  = pop && !empty;
   assign head    = mem[rd_ptr];

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (do_push) wr_ptr <= wr_ptr + 1'b1;
         if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({do_push, do_pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Storage carries data only, so it is left out of reset.
   always_ff @(posedge clk) begin
      if (do_push) mem[wr_ptr] <= push_data;
   end

endmodule

// File: rtl/uart_tx.sv
// UART transmitter, 8N1 LSB first, idle high, fed from a small byte FIFO.
// Define UART_TX_PARITY_EN to insert an even-parity bit (8E1 framing).
module uart_tx
   import uart_pkg::*;
#(
   parameter int CLK_FREQ = 100000000,
   parameter int BAUD     = 115200,
   parameter int FIFO_AW  = 4
) (
   input  logic               clk,
   input  logic               rst,
   input  logic [7:0]         tx_data,
   input  logic               tx_valid,
   output logic               tx_ready,
   output logic               tx,
   output logic               busy,
   output logic [FIFO_AW:0]   fifo_count
);
   localparam int DIVISOR = uart_divisor(CLK_FREQ, BAUD);
   localparam int CW      = $clog2(DIVISOR);

   uart_state_t                 state;
   logic [CW-1:0]               baud_cnt;
   logic [2:0]                  bit_idx;
   logic [UART_DATA_BITS-1:0]   shift;
   logic [UART_DATA_BITS-1:0]   head;
   logic                        full;
   logic                        empty;
   logic                        bit_done;
   logic                        pop;

   assign bit_done = (baud_cnt == CW'(DIVISOR - 1));
   // The FIFO head is consumed either from idle or at the very end of a stop
   // bit, which is what makes back-to-back frames gapless.
   assign pop      = !empty && ((state == ST_IDLE) || (state == ST_STOP && bit_done));
   assign tx_ready = !full;
   assign busy     = (state != ST_IDLE) || !empty;

   uart_tx_fifo #(
      .WIDTH (UART_DATA_BITS),
      .AW    (FIFO_AW)
   ) u_fifo (
      .clk       (clk),
      .rst       (rst),
      .push      (tx_valid),
      .push_data (tx_data),
      .pop       (pop),
      .head      (head),
      .count     (fifo_count),
      .full      (full),
      .empty     (empty)
   );

   always_ff @(posedge clk) begin
      if (pop) shift <= head;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= ST_IDLE;
         tx       <= UART_IDLE_LVL;
         baud_cnt <= '0;
         bit_idx  <= '0;
      end else begin
         case (state)
            ST_IDLE: begin
               tx <= UART_IDLE_LVL;
               if (!empty) begin
                  tx       <= 1'b0;
                  baud_cnt <= '0;
                  state    <= ST_START;
               end
            end
            ST_START: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shift[0];
                  state    <= ST_DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            ST_DATA: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'(UART_DATA_BITS - 1)) begin
`ifdef UART_TX_PARITY_EN
                     tx    <= ^shift;
                     state <= ST_PARITY;
`else
                     tx    <= UART_IDLE_LVL;
                     state <= ST_STOP;
`endif
                  end else begin
                     bit_idx <= bit_idx + 3'd1;
                     tx      <= shift[bit_idx + 3'd1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`ifdef UART_TX_PARITY_EN
            ST_PARITY: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  tx       <= UART_IDLE_LVL;
                  state    <= ST_STOP;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
`endif
            ST_STOP: begin
               if (bit_done) begin
                  baud_cnt <= '0;
                  if (!empty) begin
                     tx    <= 1'b0;
                     state <= ST_START;
                  end else begin
                     state <= ST_IDLE;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end
            default: begin
               tx       <= UART_IDLE_LVL;
               baud_cnt <= '0;
               state    <= ST_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx.sv
// Bench for uart_tx: per-cycle comparison against a frame-schedule model plus
// mid-bit decoding of the recorded line.
module tb_uart_tx;
   localparam int CLK_FREQ = 1152000;
   localparam int BAUD     = 115200;
   localparam int FIFO_AW  = 4;
   localparam int D        = 10;
   localparam int DEPTH    = 16;
`ifdef UART_TX_PARITY_EN
   localparam int NBITS = 11;
`else
   localparam int NBITS = 10;
`endif
   localparam int F = NBITS * D;

   logic             clk = 1'b0;
   logic             rst;
   logic [7:0]       tx_data;
   logic             tx_valid;
   logic             tx_ready;
   logic             tx;
   logic             busy;
   logic [FIFO_AW:0] fifo_count;

   uart_tx #(
      .CLK_FREQ (CLK_FREQ),
      .BAUD     (BAUD),
      .FIFO_AW  (FIFO_AW)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .tx_data    (tx_data),
      .tx_valid   (tx_valid),
      .tx_ready   (tx_ready),
      .tx         (tx),
      .busy       (busy),
      .fifo_count (fifo_count)
   );

   always #5 clk = ~clk;

   int         ncmp = 0;
   int         nfail = 0;
   int         cyc = 0;
   int         t_free = 0;
   int         acc_q[$];
   int         start_q[$];
   logic [7:0] byte_q[$];
   logic       hist[int];
   bit         last_acc;
   int         maxc;

   // Model: each accepted byte gets a frame start edge; frames never overlap
   // and follow each other without gaps while bytes are waiting.
   function automatic int mcount(input int e);
      int c = 0;
      for (int i = 0; i < acc_q.size(); i++)
         if (acc_q[i] <= e && start_q[i] > e) c++;
      return c;
   endfunction

   function automatic bit in_frame(input int e);
      for (int i = 0; i < start_q.size(); i++)
         if (start_q[i] <= e && e < start_q[i] + F) return 1'b1;
      return 1'b0;
   endfunction

   function automatic logic mtx(input int e);
      for (int i = 0; i < start_q.size(); i++) begin
         if (start_q[i] <= e && e < start_q[i] + F) begin
            int k = (e - start_q[i]) / D;
            if (k == 0) return 1'b0;
            if (k <= 8) return byte_q[i][k-1];
            if (NBITS == 11 && k == 9) return ^byte_q[i];
            return 1'b1;
         end
      end
      return 1'b1;
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      ncmp++;
      assert (obs === exp) else begin
         nfail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      acc_q.delete();
      start_q.delete();
      byte_q.delete();
      t_free = 0;
   endtask

   task automatic step(input logic v, input logic [7:0] d);
      int s;
      tx_valid = v;
      tx_data  = d;
      @(posedge clk);
      cyc++;
      last_acc = 1'b0;
      if (v && mcount(cyc - 1) < DEPTH) begin
         s = (cyc + 1 > t_free) ? cyc + 1 : t_free;
         acc_q.push_back(cyc);
         start_q.push_back(s);
         byte_q.push_back(d);
         t_free   = s + F;
         last_acc = 1'b1;
      end
      #1;
      hist[cyc] = tx;
      if (int'(fifo_count) > maxc) maxc = int'(fifo_count);
      chk("tx", tx, mtx(cyc));
      chk("fifo_count", fifo_count, mcount(cyc));
      chk("tx_ready", tx_ready, mcount(cyc) != DEPTH);
      chk("busy", busy, (mcount(cyc) > 0) || in_frame(cyc));
   endtask

   task automatic drain();
      while (cyc < t_free + 2) step(1'b0, tx_data);
   endtask

   task automatic decode(input int s, input logic [7:0] exp, input string tag);
      logic [7:0] b;
      chk({tag, "_start"}, hist[s + D/2], 1'b0);
      for (int k = 0; k < 8; k++) b[k] = hist[s + (k+1)*D + D/2];
      chk(tag, b, exp);
      if (NBITS == 11) chk({tag, "_parity"}, hist[s + 9*D + D/2], ^exp);
      chk({tag, "_stop"}, hist[s + (NBITS-1)*D + D/2], 1'b1);
   endtask

   initial begin
      int s0, s1, s2, n, guard;
      logic [7:0] d;

      rst = 1'b1; tx_valid = 1'b0; tx_data = 8'h00; maxc = 0;
      #1;
      chk("reset_tx", tx, 1'b1);
      chk("reset_busy", busy, 1'b0);
      chk("reset_ready", tx_ready, 1'b1);
      chk("reset_count", fifo_count, 0);
      repeat (2) @(posedge clk);
      #1 rst = 1'b0;

      // Single byte
      step(1'b1, 8'hA5);
      s0 = start_q[start_q.size()-1];
      chk("latency", s0, cyc + 1);
      drain();
      decode(s0, 8'hA5, "single");

      // Back-to-back burst
      step(1'b1, 8'h48); s0 = start_q[start_q.size()-1];
      step(1'b1, 8'h69); s1 = start_q[start_q.size()-1];
      step(1'b1, 8'h0D); s2 = start_q[start_q.size()-1];
      drain();
      decode(s0, 8'h48, "b2b_H");
      decode(s1, 8'h69, "b2b_i");
      decode(s2, 8'h0D, "b2b_cr");

      // Fill: valid held high until 40 bytes accepted
      n = 0; guard = 0; maxc = 0; d = 8'($urandom);
      while (n < 40 && guard < 6000) begin
         step(1'b1, d);
         guard++;
         if (last_acc) begin n++; d = 8'($urandom); end
      end
      chk("fill_accepted", n, 40);
      chk("fill_max_count", maxc, DEPTH);
      drain();

      // Random traffic
      for (int i = 0; i < 400; i++) step(($urandom % 4) == 0, 8'($urandom));
      drain();

      // Reset in the middle of bit 3 of 0x3C with bytes queued
      step(1'b1, 8'h3C); s0 = start_q[start_q.size()-1];
      for (int i = 0; i < 5; i++) step(1'b1, 8'($urandom));
      while (cyc < s0 + 45) step(1'b0, 8'h00);
      rst = 1'b1;
      #1;
      chk("midreset_tx", tx, 1'b1);
      chk("midreset_count", fifo_count, 0);
      chk("midreset_ready", tx_ready, 1'b1);
      chk("midreset_busy", busy, 1'b0);
      repeat (2) begin @(posedge clk); cyc++; end
      #1 rst = 1'b0;
      model_reset();
      step(1'b1, 8'h55); s0 = start_q[start_q.size()-1];
      drain();
      decode(s0, 8'h55, "post_reset");

      // Data changes after the accept edge must not reach the line
      step(1'b1, 8'h0F); s0 = start_q[start_q.size()-1];
      step(1'b0, 8'hF0);
      drain();
      decode(s0, 8'h0F, "stability");

      // Parity-relevant patterns (odd and even number of ones)
      step(1'b1, 8'h07); s0 = start_q[start_q.size()-1];
      step(1'b1, 8'h03); s1 = start_q[start_q.size()-1];
      drain();
      decode(s0, 8'h07, "par07");
      decode(s1, 8'h03, "par03");

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
      $finish;
   end

endmodule
